axi_word_slice: RTL and testbench

- Parametrised successor to the flat 32-bit word pass-through.
- Carries a WIDTH-bit word across a chain of STAGES full-throughput register slices with a valid/ready handshake.
- Used to break timing paths between the core-complex port wrappers and the AXI4 front end without losing bandwidth.
- Adds backpressure absorption, a synchronous flush and an occupancy count, none of which the plain pass-through has.

---
 rtl/axi_word_slice.sv | 67 ++++++
 tb/tb_axi_word_slice.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/axi_word_slice.sv
// axi_word_slice: chain of STAGES full-throughput valid/ready register slices with flush and occupancy count
module axi_word_slice #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = $clog2(2*STAGES+1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("axi_word_slice: STAGES must be in 1..4");
  end
  logic [STAGES-1:0]            mv_q, mv_d, sv_q, sv_d;
  logic [STAGES-1:0][WIDTH-1:0] md_q, md_d, sd_q, sd_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [STAGES:0]              chain_v, rdy;
  logic [STAGES:0][WIDTH-1:0]   chain_d;
  logic [STAGES-1:0]            in_fire, out_fire;
  // ready of every slice is its registered skid-empty flag, so no ready path crosses slices
  assign chain_v  = {mv_q, in_valid & ~flush};
  assign chain_d  = {md_q, in_data};
  assign rdy      = {out_ready, ~sv_q};
  assign in_fire  = chain_v[STAGES-1:0] & ~sv_q;
  assign out_fire = mv_q & rdy[STAGES:1];
  always_comb begin
    mv_d  = mv_q;
    sv_d  = sv_q;
    md_d  = md_q;
    sd_d  = sd_q;
    cnt_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      mv_d[k] = !flush && (sv_q[k] || in_fire[k] || (mv_q[k] && !out_fire[k]));
      sv_d[k] = !flush && (sv_q[k] ? !out_fire[k] : (mv_q[k] && in_fire[k] && !out_fire[k]));
      md_d[k] = sv_q[k] ? (out_fire[k] ? sd_q[k] : md_q[k])
              : (in_fire[k] && (!mv_q[k] || out_fire[k])) ? chain_d[k] : md_q[k];
      sd_d[k] = (!sv_q[k] && mv_q[k] && in_fire[k] && !out_fire[k]) ? chain_d[k] : sd_q[k];
      cnt_d   = cnt_d + CNT_W'(mv_d[k]) + CNT_W'(sv_d[k]);
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mv_q  <= '0;
      sv_q  <= '0;
      md_q  <= '0;
      sd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mv_q  <= mv_d;
      sv_q  <= sv_d;
      md_q  <= md_d;
      sd_q  <= sd_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready  = ~sv_q[0];
  assign out_valid = mv_q[STAGES-1];
  assign out_data  = md_q[STAGES-1];
  assign count     = cnt_q;
endmodule

// File: tb/tb_axi_word_slice.sv
// tb_axi_word_slice: directed and scoreboarded checks of axi_word_slice at several widths and depths
module tb_axi_word_slice;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;
  int n_assert = 0, n_fail = 0;
  logic av = 1'b0, a_rdy, aov, aor = 1'b0;
  logic [31:0] ad = '0, aod;
  logic [2:0] a_cnt;
  logic bv = 1'b0, b_rdy, bov, bor = 1'b0;
  logic [31:0] bd = '0, bod;
  logic [1:0] b_cnt;
  logic cv = 1'b0, c_rdy, cov, cor = 1'b0, d_rdy, dov;
  logic [127:0] cd = '0, c_od;
  logic dd = 1'b0, d_od;
  logic [3:0] c_cnt, d_cnt;
  int ai, ao, bi, bo;
  logic [127:0] cq[$];
  logic dq[$];
  axi_word_slice #(.WIDTH(32), .STAGES(2)) u_a (
    .clock(clk), .reset_n(rst_n), .flush(flush), .in_valid(av), .in_ready(a_rdy), .in_data(ad),
    .out_valid(aov), .out_ready(aor), .out_data(aod), .count(a_cnt));
  axi_word_slice #(.WIDTH(32), .STAGES(1)) u_b (
    .clock(clk), .reset_n(rst_n), .flush(1'b0), .in_valid(bv), .in_ready(b_rdy), .in_data(bd),
    .out_valid(bov), .out_ready(bor), .out_data(bod), .count(b_cnt));
  axi_word_slice #(.WIDTH(128), .STAGES(4)) u_c (
    .clock(clk), .reset_n(rst_n), .flush(1'b0), .in_valid(cv), .in_ready(c_rdy), .in_data(cd),
    .out_valid(cov), .out_ready(cor), .out_data(c_od), .count(c_cnt));
  axi_word_slice #(.WIDTH(1), .STAGES(4)) u_d (
    .clock(clk), .reset_n(rst_n), .flush(1'b0), .in_valid(cv), .in_ready(d_rdy), .in_data(dd),
    .out_valid(dov), .out_ready(cor), .out_data(d_od), .count(d_cnt));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic a_cycle(input int lim, input logic [31:0] base);
    logic fin, fout;
    fin  = av && a_rdy;
    fout = aov && aor;
    if (fout) begin
      chk("a_out_order", aod, base + ao);
      ao++;
    end
    @(posedge clk); #1;
    if (fin) ai++;
    av = ai < lim;
    ad = base + ai;
  endtask
  initial begin
    logic fin_c, fin_d, rdy0, bfin, bfout;
    logic [127:0] ce;
    logic de;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_out_valid", aov, 0);
    chk("rst_hold_in_ready", a_rdy, 1);
    rst_n = 1'b1;
    chk("rst_out_valid", aov, 0);
    chk("rst_out_data", aod, 0);
    chk("rst_in_ready", a_rdy, 1);
    chk("rst_count", a_cnt, 0);
    chk("rst_count_c", c_cnt, 0);
    chk("rst_in_ready_b", b_rdy, 1);
    av = 1'b1; ad = 32'h1; aor = 1'b1;
    for (int j = 0; j < 18; j++) begin
      @(posedge clk); #1;
      chk("stream_valid", aov, (j >= 1 && j <= 16));
      if (j >= 1 && j <= 16) chk("stream_data", aod, j);
      chk("stream_count", a_cnt, j == 0 ? 1 : j <= 15 ? 2 : j == 16 ? 1 : 0);
      chk("stream_in_ready", a_rdy, 1);
      ad = j + 2;
      av = (j + 1 < 16);
    end
    ai = 0; ao = 0; av = 1'b1; ad = 32'hA0; aor = 1'b0;
    repeat (8) a_cycle(6, 32'hA0);
    chk("bp_accepted", ai, 4);
    chk("bp_in_ready", a_rdy, 0);
    chk("bp_count", a_cnt, 4);
    chk("bp_out_valid", aov, 1);
    chk("bp_out_data", aod, 32'hA0);
    aor = 1'b1;
    for (int c = 0; c < 20; c++) begin
      a_cycle(6, 32'hA0);
      if (c == 0) chk("full_ready_lag", a_rdy, 0);
      if (c == 1) chk("full_ready_back", a_rdy, 1);
    end
    chk("bp_all_out", ao, 6);
    chk("bp_all_in", ai, 6);
    chk("bp_drained", a_cnt, 0);
    ai = 0; ao = 0; av = 1'b1; ad = 32'h30; aor = 1'b0;
    repeat (3) a_cycle(3, 32'h30);
    chk("flush_pre_count", a_cnt, 3);
    flush = 1'b1; av = 1'b1; ad = 32'h55;
    chk("flush_in_ready", a_rdy, 1);
    @(posedge clk); #1;
    flush = 1'b0; av = 1'b0;
    chk("flush_count", a_cnt, 0);
    chk("flush_out_valid", aov, 0);
    aor = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("flush_no_55", aov, 0);
    end
    bi = 0; bo = 0;
    for (int c = 0; c < 30; c++) begin
      bv = (c < 20);
      bd = bi;
      rdy0 = b_rdy;
      bor = (c >= 20) ? 1'b1 : (c % 2 == 1);
      #1;
      chk("skid_ready_no_comb", b_rdy, rdy0);
      bfin = bv && b_rdy;
      bfout = bov && bor;
      if (bfout) begin
        chk("skid_order", bod, bo);
        bo++;
      end
      @(posedge clk); #1;
      if (bfin) bi++;
    end
    chk("skid_no_loss", bo, bi);
    chk("skid_count", b_cnt, 0);
    cd = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int c = 0; c < 330; c++) begin
      chk("c_occupancy", c_cnt, cq.size());
      chk("d_occupancy", d_cnt, dq.size());
      chk("c_count_max", c_cnt <= 8, 1);
      fin_c = cv && c_rdy;
      fin_d = cv && d_rdy;
      if (cov && cor) begin
        if (cq.size() > 0) ce = cq.pop_front(); else ce = 'x;
        chk("c_order", c_od, ce);
      end
      if (dov && cor) begin
        if (dq.size() > 0) de = dq.pop_front(); else de = 1'bx;
        chk("d_order", d_od, de);
      end
      if (fin_c) cq.push_back(cd);
      if (fin_d) dq.push_back(dd);
      @(posedge clk); #1;
      if (!cv || fin_c) begin
        cv = (c < 300) && ($urandom_range(0, 3) != 0);
        cd = {$urandom(), $urandom(), $urandom(), $urandom()};
        dd = 1'($urandom_range(0, 1));
      end
      cor = (c >= 300) || ($urandom_range(0, 2) != 0);
    end
    chk("c_drained", cq.size(), 0);
    chk("d_drained", dq.size(), 0);
    chk("c_final_count", c_cnt, 0);
    chk("d_final_count", d_cnt, 0);
    ai = 0; ao = 0; av = 1'b1; ad = 32'h70; aor = 1'b0;
    repeat (3) a_cycle(3, 32'h70);
    chk("mid_pre_count", a_cnt, 3);
    chk("mid_pre_valid", aov, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", aov, 0);
    chk("mid_rst_data", aod, 0);
    chk("mid_rst_count", a_cnt, 0);
    chk("mid_rst_in_ready", a_rdy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_release_count", a_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
